cobertura_ctrl: RTL
===================

Name: cobertura_ctrl

Overview:
- Sequential, parametrised controller for a retractable cover with N_PANELS independently driven panels.
- Debounces the light (L) and rain/humidity (U) sensors and adds a manual override mode.
- Runs one motor FSM per panel, with open/close limit switches, reversal dead-time and a motor timeout that raises a fault.
- Sits between raw sensor/switch inputs and the motor driver outputs A (open) and F (close).

Parameters:
- N_PANELS, 2, number of independently driven panels (1..8).
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced L/U value changes (≥1).
- TIMEOUT, 16, maximum cycles a panel may run in one direction without reaching its limit switch (≥2).
- TW, 5, timer width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- L  input  1  light sensor raw; 1 = light present (close demand).
- U  input  1  rain/humidity sensor raw; 1 = wet (close demand, highest priority).
- Fd  input  N_PANELS  per-panel fully-open limit switch, 1 = reached.
- Fe  input  N_PANELS  per-panel fully-closed limit switch, 1 = reached.
- man_en  input  1  manual mode enable.
- man_open  input  1  manual open command, valid when man_en=1.
- man_close  input  1  manual close command, valid when man_en=1.
- fault_clr  input  1  single-cycle pulse; clears every panel in FAULT.
- A  output  N_PANELS  per-panel open motor drive, registered.
- F  output  N_PANELS  per-panel close motor drive, registered.
- fault  output  N_PANELS  per-panel fault flag, registered.
- busy  output  1  OR of (A|F) over all panels.

Behaviour:
- Reset (rst_n=0, async):
  - A=F=fault=0, busy=0.
  - All panels in STOP; timers 0.
  - Debounced Ld=Ud=0; debounce counters 0.
- Debounce (L and U only):
  - The filtered value follows the raw value once the raw value has differed from it for DEB_CYCLES consecutive rising edges; the update occurs on that edge.
  - Any glitch shorter than DEB_CYCLES restarts the count.
  - Limit switches and manual inputs are not debounced.
- Demand, computed combinationally each cycle:
  - Ud=1: close_req=1, open_req=0. Rain overrides manual mode.
  - Else if man_en=1: close_req=man_close, open_req=man_open&~man_close. Neither asserted means hold: no new motion; a moving panel goes to STOP.
  - Else: close_req=Ld, open_req=~Ld.
- Per-panel FSM states: STOP, OPENING, CLOSING, REVERSE, FAULT.
- STOP:
  - close_req & ~Fe[i] -> CLOSING.
  - Else open_req & ~Fd[i] -> OPENING.
  - Else stay.
- OPENING (A[i]=1), priority order:
  - Fd[i] -> STOP.
  - close_req -> REVERSE.
  - hold (manual, neither command) -> STOP.
  - timer==TIMEOUT-1 -> FAULT.
  - Otherwise timer+1.
- CLOSING (F[i]=1): symmetric to OPENING, using Fe[i] and open_req.
- REVERSE:
  - A=F=0 for exactly one cycle, then STOP. STOP re-evaluates the demand on the next edge.
  - Guarantees at least 2 idle cycles between opposite drives.
- FAULT:
  - A=F=0, fault[i]=1.
  - Exits to STOP only on fault_clr=1.
- Any non-FAULT state with Fd[i]&Fe[i]=1 -> FAULT. This check has the highest priority.
- Timer: cleared on entry to OPENING/CLOSING; saturates, never wraps.
- Outputs:
  - A and F are decoded from the registered state.
  - A[i]&F[i] never both 1.
- Latency:
  - Raw L edge to A/F change: DEB_CYCLES+1 edges.
  - Limit switch to motor off: 1 edge.
- Reset mid-motion: drives drop immediately (async); no timeout carry-over.

Decomposition:
- Package cobertura_pkg holds:
  - state encoding constants: STOP=0, OPENING=1, CLOSING=2, REVERSE=3, FAULT=4 (3 bits).
  - defaults for DEB_CYCLES and TIMEOUT.
- Sub-module cobertura_debounce (params DEB_CYCLES; ports clk, rst_n, din, dout), instanced for L and U.
- Per-panel FSM in a generate loop inside cobertura_ctrl.

Test Plan:
1. Reset, then L=0, U=0, Fd=00, Fe=11, man_en=0 -> after 5 edges A=11, F=00. Raise Fd[0] -> A[0]=0 next edge while A[1] stays 1.
2. Panels opening; L=1 for 3 cycles then 0 -> A unchanged (glitch rejected). L=1 held 4 cycles -> REVERSE: A=00, F=00 for 1 cycle, STOP 1 cycle, then F=11.
3. Panels closing; Fe held 00 for 16 cycles -> fault=11, F=00. fault_clr pulse with demand still close -> STOP, then CLOSING restarts with the timer at 0.
4. man_en=1, man_open=1, U=0, L=1 -> panels open. Raise U for 4 cycles -> close overrides manual, F=11.
5. Fd[1]=Fe[1]=1 while idle -> fault[1]=1 next edge; panel 0 unaffected.
6. rst_n low mid-CLOSING -> F=00 immediately; after release, FSM in STOP and the timer restarts from 0.

Source files
------------

// File: rtl/cobertura_pkg.sv
// Shared state encoding and parameter defaults for the retractable cover controller.
package cobertura_pkg;

  typedef enum logic [2:0] {
    STOP    = 3'd0,
    OPENING = 3'd1,
    CLOSING = 3'd2,
    REVERSE = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;
  localparam int TW_DEF         = 5;

endpackage

// File: rtl/cobertura_debounce.sv
// Single-bit debouncer: output follows input after DEB_CYCLES consecutive differing edges.
module cobertura_debounce
  import cobertura_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_dout;

  // r_cnt holds the number of earlier consecutive edges that saw din differ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else if (din == r_dout) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
      r_dout <= din;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/cobertura_ctrl.sv
// Retractable cover controller: debounced light/rain demand, manual override,
// and one motor FSM per panel with limit switches, reversal dead-time and timeout fault.
module cobertura_ctrl
  import cobertura_pkg::*;
#(
  parameter int N_PANELS   = 2,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int TW         = TW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                L,
  input  logic                U,
  input  logic [N_PANELS-1:0] Fd,
  input  logic [N_PANELS-1:0] Fe,
  input  logic                man_en,
  input  logic                man_open,
  input  logic                man_close,
  input  logic                fault_clr,
  output logic [N_PANELS-1:0] A,
  output logic [N_PANELS-1:0] F,
  output logic [N_PANELS-1:0] fault,
  output logic                busy
);

  logic w_ld;
  logic w_ud;
  logic w_close_req;
  logic w_open_req;
  logic w_hold;

  cobertura_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (L),
    .dout (w_ld)
  );

  cobertura_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_u (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (U),
    .dout (w_ud)
  );

  // Rain beats everything, manual beats light; hold only exists in manual mode
  always_comb begin
    w_close_req = 1'b0;
    w_open_req  = 1'b0;
    w_hold      = 1'b0;
    if (w_ud) begin
      w_close_req = 1'b1;
    end else if (man_en) begin
      w_close_req = man_close;
      w_open_req  = man_open & ~man_close;
      w_hold      = ~man_open & ~man_close;
    end else begin
      w_close_req = w_ld;
      w_open_req  = ~w_ld;
    end
  end

  for (genvar gi = 0; gi < N_PANELS; gi++) begin : g_panel
    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic          r_a;
    logic          r_f;
    logic          r_fault;

    always_comb begin
      w_state_next = r_state;
      w_timer_next = r_timer;
      if ((r_state != FAULT) && Fd[gi] && Fe[gi]) begin
        w_state_next = FAULT;
      end else begin
        case (r_state)
          STOP: begin
            if (w_close_req && !Fe[gi]) begin
              w_state_next = CLOSING;
              w_timer_next = '0;
            end else if (w_open_req && !Fd[gi]) begin
              w_state_next = OPENING;
              w_timer_next = '0;
            end
          end
          OPENING: begin
            if (Fd[gi])                             w_state_next = STOP;
            else if (w_close_req)                   w_state_next = REVERSE;
            else if (w_hold)                        w_state_next = STOP;
            else if (r_timer == TW'(TIMEOUT - 1))   w_state_next = FAULT;
            else if (r_timer != '1)                 w_timer_next = r_timer + 1'b1;
          end
          CLOSING: begin
            if (Fe[gi])                             w_state_next = STOP;
            else if (w_open_req)                    w_state_next = REVERSE;
            else if (w_hold)                        w_state_next = STOP;
            else if (r_timer == TW'(TIMEOUT - 1))   w_state_next = FAULT;
            else if (r_timer != '1)                 w_timer_next = r_timer + 1'b1;
          end
          REVERSE: w_state_next = STOP;
          FAULT:   if (fault_clr) w_state_next = STOP;
          default: w_state_next = STOP;
        endcase
      end
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= STOP;
        r_timer <= '0;
        r_a     <= 1'b0;
        r_f     <= 1'b0;
        r_fault <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_timer <= w_timer_next;
        r_a     <= (w_state_next == OPENING);
        r_f     <= (w_state_next == CLOSING);
        r_fault <= (w_state_next == FAULT);
      end
    end

    assign A[gi]     = r_a;
    assign F[gi]     = r_f;
    assign fault[gi] = r_fault;
  end

  assign busy = |(A | F);

endmodule
